writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DEPTH, default 4: number of pending-write buffer entries; power of two, 2..16.
REQ-002 Parameter XLEN, default 32: data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream presents a result.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_data  input  XLEN  result value.
REQ-009 wb_stall  input  1  register-file write port unavailable this cycle.
REQ-010 wr_en  output  1  register-file write strobe.
REQ-011 wr_addr  output  5  register-file write index.
REQ-012 wr_data  output  XLEN  register-file write value.
REQ-013 rs1, rs2  input  5 each  read indices also presented to the register file.
REQ-014 fwd1_hit, fwd2_hit  output  1 each  pending write exists for rs1/rs2.
REQ-015 fwd1_data, fwd2_data  output  XLEN each  youngest pending value for rs1/rs2.
REQ-016 empty  output  1  no pending writes; used by the pipeline to drain.

Function
REQ-017 Accept (push) occurs when in_valid && in_ready at a rising edge.
REQ-018 in_ready SHALL equal !full, from registered count; no combinational path from wr_en/wb_stall.
REQ-019 An accepted result with in_rd == 0 SHALL be discarded: handshake completes, nothing enqueued.
REQ-020 Entries SHALL be held in FIFO order; wr_en = !empty; wr_addr/wr_data = head entry, combinationally from storage.
REQ-021 Pop occurs when wr_en && !wb_stall; head advances next cycle.
REQ-022 Minimum latency: result accepted in cycle N appears on wr_* in cycle N+1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push when full is impossible (in_ready low).
REQ-024 Head/tail pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH+1) and range 0..DEPTH.
REQ-025 empty = (count == 0); full = (count == DEPTH).
REQ-026 Multiple pending entries with the same rd are permitted; all are written in order.
REQ-027 wb_stall held high SHALL freeze wr_addr/wr_data stable with wr_en high until released.

Reset
REQ-028 On rst_n low, immediately: head, tail, count = 0; wr_en = 0; empty = 1; in_ready = 1; fwd*_hit = 0.
REQ-029 Pending entries are lost on reset mid-operation; storage data need not be cleared.
REQ-030 First accept is permitted in the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro WB_FORWARD_EN: when defined, fwdN_hit = 1 iff a valid entry has rd == rsN and rsN != 0; fwdN_data = youngest such entry's data (youngest wins), combinational.
REQ-032 When WB_FORWARD_EN is undefined, fwd*_hit SHALL be constant 0 and fwd*_data constant 0; no comparator logic synthesized.

Structure
REQ-033 Shared package SHALL hold the entry struct typedef (rd 5 bits, data XLEN) and constant REG_ZERO = 5'd0.
REQ-034 One sub-module, wb_fwd_lookup, SHALL implement the per-port youngest-match search; instantiated twice under WB_FORWARD_EN.

Verification
REQ-035 Reset then push (rd=5, 0xDEADBEEF), wb_stall=0 -> next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle empty=1.
REQ-036 wb_stall=1, push 4 results (rd 1..4) -> in_ready=0 after fourth; 5th in_valid held, not accepted; release stall -> writes rd 1,2,3,4 in order on consecutive cycles.
REQ-037 Push rd=0 data 0x1234 -> in_ready handshake completes, wr_en never asserts, empty stays 1.
REQ-038 WB_FORWARD_EN, stall=1, push (rd=7,0x11) then (rd=7,0x22), rs1=7 -> fwd1_hit=1, fwd1_data=0x22; rs2=0 -> fwd2_hit=0.
REQ-039 Count=3, simultaneous push and pop for 10 cycles -> count stays 3, pointers wrap, write order matches push order.
REQ-040 Assert rst_n low mid-cycle with 3 entries pending -> wr_en drops to 0 before next edge; after release empty=1, in_ready=1.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage and its forwarding lookup.
package writeback_stage_pkg;

  // Storage is sized for the widest supported datapath; narrower builds use the low bits.
  localparam int XLEN_MAX = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search of the pending-write buffer for one register read port.
module wb_fwd_lookup
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wb_entry_t                    ents [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [4:0]                   rs,
  output logic                         hit,
  output logic [XLEN-1:0]              data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ents[idx].rd == rs) && (rs != REG_ZERO)) begin
        hit  = 1'b1;
        data = ents[idx].data[XLEN-1:0];
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Register-file writeback buffer: FIFO of pending writes drained under wb_stall.
// Optional macro WB_FORWARD_EN adds youngest-pending-value forwarding for rs1/rs2.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            wb_stall,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign wr_en    = !empty;
  assign wr_addr  = mem[head].rd;
  assign wr_data  = mem[head].data[XLEN-1:0];

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push = in_valid && in_ready && (in_rd != REG_ZERO);
  assign pop  = wr_en && !wb_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rd: in_rd, data: XLEN_MAX'(in_data)};
  end

`ifdef WB_FORWARD_EN
  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
    .ents  (mem),
    .head  (head),
    .count (count),
    .rs    (rs1),
    .hit   (fwd1_hit),
    .data  (fwd1_data)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
    .ents  (mem),
    .head  (head),
    .count (count),
    .rs    (rs2),
    .hit   (fwd2_hit),
    .data  (fwd2_data)
  );
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed table, hand sequences and a randomized run
// checked against a queue-based model of the pending-write buffer.
module tb_writeback_stage;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            wb_stall;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwd1_hit;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd2_data;
  logic            empty;

  writeback_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wb_stall  (wb_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  typedef struct {
    logic            v;
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
    logic            st;
    logic            x_ready;
    logic            x_wen;
    logic [4:0]      x_addr;
    logic [XLEN-1:0] x_data;
    logic            x_empty;
  } vec_t;

  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected forward result: scan the pending queue from youngest to oldest.
  task automatic fwd_ref(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WB_FORWARD_EN
    if (rs != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].rd == rs) begin
          hit  = 1'b1;
          data = q[i].data;
        end
      end
    end
`endif
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d,
                       input logic st, input logic [4:0] r1, input logic [4:0] r2);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wb_stall = st;
    rs1      = r1;
    rs2      = r2;
  endtask

  task automatic check_model();
    logic            h;
    logic [XLEN-1:0] dd;
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("wr_en",    64'(wr_en),    64'(q.size() != 0));
    chk("empty",    64'(empty),    64'(q.size() == 0));
    if (q.size() != 0) begin
      chk("wr_addr", 64'(wr_addr), 64'(q[0].rd));
      chk("wr_data", 64'(wr_data), 64'(q[0].data));
    end
    fwd_ref(rs1, h, dd);
    chk("fwd1_hit",  64'(fwd1_hit),  64'(h));
    chk("fwd1_data", 64'(fwd1_data), 64'(dd));
    fwd_ref(rs2, h, dd);
    chk("fwd2_hit",  64'(fwd2_hit),  64'(h));
    chk("fwd2_data", 64'(fwd2_data), 64'(dd));
  endtask

  // Take the clock edge and apply the same accept/retire rules to the model queue.
  task automatic advance();
    logic acc;
    logic pp;
    acc = in_valid && (q.size() < DEPTH);
    pp  = (q.size() != 0) && !wb_stall;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc && in_rd != 5'd0) q.push_back('{rd: in_rd, data: in_data});
    #1;
  endtask

  task automatic cycle(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d,
                       input logic st, input logic [4:0] r1, input logic [4:0] r2);
    drive(v, rd, d, st, r1, r2);
    #2;
    check_model();
    advance();
  endtask

  vec_t vecs [16];

  initial begin
    logic            exp_hit;
    logic [XLEN-1:0] exp_dat;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 5'd1, 32'h101,      1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 5'd2, 32'h102,      1'b1, 1'b1, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[7]  = '{1'b1, 5'd3, 32'h103,      1'b1, 1'b1, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[8]  = '{1'b1, 5'd4, 32'h104,      1'b1, 1'b1, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[9]  = '{1'b1, 5'd5, 32'h105,      1'b1, 1'b0, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[10] = '{1'b1, 5'd5, 32'h105,      1'b1, 1'b0, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd1, 32'h101,      1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd2, 32'h102,      1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'h103,      1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4, 32'h104,      1'b0};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd3, 5'd0);
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_wr_en",    64'(wr_en),    64'(0));
    chk("rst_empty",    64'(empty),    64'(1));
    chk("rst_fwd1_hit", 64'(fwd1_hit), 64'(0));
    #9;
    rst_n = 1'b1;

    // Directed table: first accept lands on the first edge after reset release.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].st, 5'd0, 5'd0);
      #2;
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].x_ready));
      chk($sformatf("vec%0d_wen", i),   64'(wr_en),    64'(vecs[i].x_wen));
      chk($sformatf("vec%0d_empty", i), 64'(empty),    64'(vecs[i].x_empty));
      if (vecs[i].x_wen) begin
        chk($sformatf("vec%0d_addr", i), 64'(wr_addr), 64'(vecs[i].x_addr));
        chk($sformatf("vec%0d_data", i), 64'(wr_data), 64'(vecs[i].x_data));
      end
      check_model();
      advance();
    end

    // Two pending writes to the same register: youngest value forwards.
    cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0);
    #2;
`ifdef WB_FORWARD_EN
    exp_hit = 1'b1;
    exp_dat = 32'h22;
`else
    exp_hit = 1'b0;
    exp_dat = 32'h0;
`endif
    chk("fwd_same_rd_hit",  64'(fwd1_hit),  64'(exp_hit));
    chk("fwd_same_rd_data", 64'(fwd1_data), 64'(exp_dat));
    chk("fwd_x0_hit",       64'(fwd2_hit),  64'(0));
    check_model();
    advance();
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);
    chk("drained_empty", 64'(empty), 64'(1));

    // Hold three entries, then push and pop together so the pointers wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'd11, 5'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'(1 + i), 32'hB000 + i, 1'b0, 5'(1 + i), 5'd12);
      chk($sformatf("steady_count_%0d", i), 64'(q.size()), 64'(3));
    end

    // Asynchronous reset in the middle of a cycle with three pending writes.
    drive(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en",    64'(wr_en),    64'(0));
    chk("midrst_empty",    64'(empty),    64'(1));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_fwd1_hit", 64'(fwd1_hit), 64'(0));
    q.delete();
    #2;
    rst_n = 1'b1;
    check_model();
    advance();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    chk("final_empty", 64'(empty), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
